// File: rtl/memory_stage.sv
// Memory-access pipeline stage: drives a req/ack data-memory port for aligned doubleword
// loads and stores, stalls upstream while an access is outstanding, and resolves CBZ branches.
module memory_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_M,
    input  logic        MemRead_M,
    input  logic        MemWrite_M,
    input  logic        Branch_M,
    input  logic        zero_M,
    input  logic [63:0] aluResult_M,
    input  logic [63:0] writeData_M,
    output logic        PCSrc_M,
    output logic        stall_M,
    output logic        done_M,
    output logic [63:0] readData_M,
    output logic        align_err,
    output logic        bus_err,
    output logic        dm_req,
    output logic        dm_we,
    output logic [63:0] dm_addr,
    output logic [63:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [63:0] dm_rdata
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          mem_op;
    logic          misaligned;
    logic          accept;

    assign mem_op     = valid_M & (MemRead_M | MemWrite_M);
    assign misaligned = aluResult_M[2:0] != 3'b000;
    assign accept     = (state == IDLE) & mem_op & ~misaligned;

    // Branch resolution never waits on the memory FSM.
    assign PCSrc_M = valid_M & Branch_M & zero_M;
    assign stall_M = accept | (state == ACCESS);
    assign done_M  = (state == DONE) | ((state == IDLE) & valid_M & ~accept);

    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: every register, including the captured bus fields, is cleared here so a
            // reset mid-access leaves nothing stale on the memory port.
            state      <= IDLE;
            wait_cnt   <= '0;
            dm_req     <= 1'b0;
            dm_we      <= 1'b0;
            dm_addr    <= '0;
            dm_wdata   <= '0;
            readData_M <= '0;
            align_err  <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            align_err <= 1'b0;
            bus_err   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        dm_addr  <= aluResult_M;
                        dm_wdata <= writeData_M;
                        // A simultaneous read+write request is resolved as a store.
                        dm_we    <= MemWrite_M;
                        wait_cnt <= '0;
                        dm_req   <= 1'b1;
                        state    <= ACCESS;
                    end else if (mem_op) begin
                        align_err  <= 1'b1;
                        readData_M <= '0;
                    end
                end
                ACCESS: begin
                    if (dm_ack) begin
                        if (!dm_we) begin
                            readData_M <= dm_rdata;
                        end
                        dm_req <= 1'b0;
                        state  <= DONE;
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        readData_M <= '0;
                        bus_err    <= 1'b1;
                        dm_req     <= 1'b0;
                        state      <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    dm_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: a driver issues random and directed instructions and
// pushes expected outcomes; a negedge monitor pops and compares whenever done_M is seen.
module tb_memory_stage;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_M, MemRead_M, MemWrite_M, Branch_M, zero_M;
    logic [63:0] aluResult_M, writeData_M;
    logic        PCSrc_M, stall_M, done_M, align_err, bus_err;
    logic [63:0] readData_M;
    logic        dm_req, dm_we, dm_ack;
    logic [63:0] dm_addr, dm_wdata, dm_rdata;

    memory_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .valid_M(valid_M), .MemRead_M(MemRead_M), .MemWrite_M(MemWrite_M),
        .Branch_M(Branch_M), .zero_M(zero_M),
        .aluResult_M(aluResult_M), .writeData_M(writeData_M),
        .PCSrc_M(PCSrc_M), .stall_M(stall_M), .done_M(done_M),
        .readData_M(readData_M), .align_err(align_err), .bus_err(bus_err),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          issue_cyc;
        bit          pcsrc;
        bit          aligned_mem;
        bit          misaligned;
        bit          timeout;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rd;
        int          lat;
        int          stalls;
        int          reqs;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          mon_en = 0;
    bit          hung = 0;
    bit          align_pend = 0;
    int          stall_cnt = 0;
    int          req_cnt = 0;
    logic [63:0] model_rd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every retiring instruction against the front of the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            stall_cnt += int'(stall_M);
            req_cnt   += int'(dm_req);
            check("align_err", {63'd0, align_err}, {63'd0, align_pend});
            if (align_pend) check("align_rd_zero", readData_M, 64'd0);
            align_pend = 0;
            if (done_M) begin
                if (sb.size() == 0) begin
                    check("spurious_done", {63'd0, done_M}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("latency", 64'(cyc - e.issue_cyc + 1), 64'(e.lat));
                    check("stall_cycles", 64'(stall_cnt), 64'(e.stalls));
                    check("req_cycles", 64'(req_cnt), 64'(e.reqs));
                    check("pcsrc", {63'd0, PCSrc_M}, {63'd0, e.pcsrc});
                    check("bus_err", {63'd0, bus_err}, {63'd0, e.timeout});
                    if (!e.misaligned) check("read_data", readData_M, e.rd);
                    if (e.aligned_mem) begin
                        check("dm_addr", dm_addr, e.addr);
                        check("dm_wdata", dm_wdata, e.wdata);
                        check("dm_we", {63'd0, dm_we}, {63'd0, e.we});
                    end
                    align_pend = e.misaligned;
                end
                stall_cnt = 0;
                req_cnt   = 0;
            end else begin
                check("bus_err_quiet", {63'd0, bus_err}, 64'd0);
                if (!valid_M) check("pcsrc_bubble", {63'd0, PCSrc_M}, 64'd0);
            end
        end
    end

    // Driver: presents one instruction, pushes its expected outcome, and plays the memory.
    // n_ack is the ACCESS cycle carrying dm_ack; values beyond TIMEOUT mean no ack at all.
    task automatic issue(input logic v, rd, wr, br, z, input logic [63:0] addr, wd, ack_data,
                         input int n_ack);
        exp_t e;
        int   acc;
        bit   mem, done_seen;
        mem = v & (rd | wr);
        valid_M = v; MemRead_M = rd; MemWrite_M = wr; Branch_M = br; zero_M = z;
        aluResult_M = addr; writeData_M = wd;
        e.issue_cyc   = cyc;
        e.pcsrc       = v & br & z;
        e.misaligned  = mem && (addr % 8 != 0);
        e.aligned_mem = mem && !e.misaligned;
        e.timeout     = e.aligned_mem && (n_ack > TIMEOUT);
        e.we          = wr;
        e.addr        = addr;
        e.wdata       = wd;
        acc           = e.timeout ? TIMEOUT : n_ack;
        e.lat         = e.aligned_mem ? acc + 2 : 1;
        e.stalls      = e.aligned_mem ? acc + 1 : 0;
        e.reqs        = e.aligned_mem ? acc : 0;
        if (e.misaligned || e.timeout) model_rd = '0;
        else if (e.aligned_mem && !wr) model_rd = ack_data;
        e.rd = model_rd;
        if (!v) begin
            dm_ack = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            return;
        end
        sb.push_back(e);
        for (int c = 0; ; c++) begin
            if (c == n_ack) begin
                dm_ack = 1'b1;
                dm_rdata = ack_data;
            end else begin
                dm_ack = (c == 0 || c == n_ack + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                dm_rdata = {$urandom, $urandom};
            end
            @(negedge clk);
            done_seen = done_M;
            @(posedge clk); #1;
            if (done_seen) break;
            if (c > 40) begin
                checks++; errors++;
                $display("FAIL done_timeout: no done_M after %0d cycles", c);
                hung = 1;
                break;
            end
        end
        dm_ack = 1'b0;
    endtask

    initial begin
        logic [63:0] a;
        int          k, r, n;
        reset = 1'b0; valid_M = 0; MemRead_M = 0; MemWrite_M = 0; Branch_M = 0; zero_M = 0;
        aluResult_M = '0; writeData_M = '0; dm_ack = 1'b1; dm_rdata = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dm_req", {63'd0, dm_req}, 64'd0);
        check("rst_read_data", readData_M, 64'd0);
        check("rst_dm_addr", dm_addr, 64'd0);
        check("rst_stall", {63'd0, stall_M}, 64'd0);
        check("rst_done", {63'd0, done_M}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b1; dm_ack = 1'b0;
        mon_en = 1;

        // Directed cases from the feature list, then boundary ack on the last ACCESS cycle.
        issue(1, 1, 0, 0, 0, 64'h40, 64'h0, 64'hDEADBEEF, 1);
        issue(1, 0, 1, 0, 0, 64'h18, 64'h2B, 64'h5555, 3);
        issue(1, 0, 0, 1, 1, 64'h0, 64'h0, 64'h0, 1);
        issue(1, 0, 0, 1, 0, 64'h0, 64'h0, 64'h0, 1);
        issue(1, 1, 0, 0, 0, 64'h1C, 64'h0, 64'h0, 1);
        issue(1, 1, 0, 0, 0, 64'h20, 64'h0, 64'h77, 99);
        issue(1, 1, 0, 0, 0, 64'h28, 64'h0, 64'hCAFE, TIMEOUT);
        issue(1, 1, 1, 0, 1, 64'h30, 64'h99, 64'h1111, 2);

        for (int i = 0; i < 250 && !hung; i++) begin
            k = $urandom_range(0, 9);
            a = {$urandom, $urandom};
            a[2:0] = (k == 9) ? 3'($urandom_range(1, 7)) : 3'd0;
            r = $urandom_range(0, 19);
            n = (r == 0) ? 99 : (r == 1) ? TIMEOUT : 1 + (r % 4);
            issue(k != 0, k inside {[3:5], 8, 9} ? 1'b1 : 1'b0, k inside {[6:8]} ? 1'b1 : 1'($urandom_range(0, 1) & (k == 9)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  a, {$urandom, $urandom}, {$urandom, $urandom}, n);
        end

        if (!hung) begin
            // Mid-access reset: load issued, reset asserted in its second ACCESS cycle.
            issue(1, 1, 0, 0, 0, 64'h100, 64'h0, 64'h1234_5678, 1);
            mon_en = 0;
            valid_M = 1; MemRead_M = 1; MemWrite_M = 0; Branch_M = 0;
            aluResult_M = 64'h80; writeData_M = 64'hABCD; dm_ack = 0;
            @(posedge clk); #1;
            @(posedge clk); #1;
            reset = 1'b0;
            @(negedge clk);
            check("pre_reset_req", {63'd0, dm_req}, 64'd1);
            @(posedge clk); #1;
            reset = 1'b1; valid_M = 0; dm_ack = 1'b1; dm_rdata = 64'hFFFF;
            @(negedge clk);
            check("mid_rst_req", {63'd0, dm_req}, 64'd0);
            check("mid_rst_addr", dm_addr, 64'd0);
            check("mid_rst_wdata", dm_wdata, 64'd0);
            check("mid_rst_read", readData_M, 64'd0);
            check("mid_rst_stall", {63'd0, stall_M}, 64'd0);
            check("mid_rst_done", {63'd0, done_M}, 64'd0);
            @(posedge clk); #1;
            @(negedge clk);
            check("late_ack_req", {63'd0, dm_req}, 64'd0);
            check("late_ack_read", readData_M, 64'd0);
            check("late_ack_done", {63'd0, done_M}, 64'd0);
            dm_ack = 1'b0;
            check("sb_empty", 64'(sb.size()), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
